// File: rtl/bitwise_arbiter.sv
// Two-requester round-robin front end for a shared AND/OR/XOR unit, with one
// registered response slot handshaked by valid/ready.

module bitwise #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ctrl,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (ctrl)
            2'b00:   res = a & b;
            2'b01:   res = a | b;
            2'b10:   res = a ^ b;
            default: res = '0;
        endcase
    end

endmodule

module bitwise_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_res,
    output logic             resp_err,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             respValid_q, respValid_d;
    logic             respId_q,    respId_d;
    logic [WIDTH-1:0] respRes_q,   respRes_d;
    logic             respErr_q,   respErr_d;
    logic             rrPtr_q,     rrPtr_d;
    logic [CNT_W-1:0] cnt0_q,      cnt0_d;
    logic [CNT_W-1:0] cnt1_q,      cnt1_d;

    logic             slotFree;
    logic             grantValid;
    logic             grantId;
    logic             accept;
    logic [WIDTH-1:0] unitA, unitB, unitRes;
    logic [1:0]       opSel;

    // Under contention the round-robin pointer picks; it only moves on accept.
    assign slotFree   = !respValid_q || resp_ready;
    assign grantValid = req0_valid || req1_valid;
    assign grantId    = (req0_valid && req1_valid) ? rrPtr_q : req1_valid;
    assign accept     = rst_n && slotFree && grantValid;

    assign req0_ready = accept && !grantId;
    assign req1_ready = accept &&  grantId;

    assign unitA = grantId ? req1_a  : req0_a;
    assign unitB = grantId ? req1_b  : req0_b;
    assign opSel = grantId ? req1_op : req0_op;

    bitwise #(.WIDTH(WIDTH)) u_bitwise (
        .a    (unitA),
        .b    (unitB),
        .ctrl (opSel),
        .res  (unitRes)
    );

    always_comb begin
        respValid_d = respValid_q;
        respId_d    = respId_q;
        respRes_d   = respRes_q;
        respErr_d   = respErr_q;
        rrPtr_d     = rrPtr_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        if (accept) begin
            respValid_d = 1'b1;
            respId_d    = grantId;
            respErr_d   = (opSel == 2'b11);
            respRes_d   = (opSel == 2'b11) ? '0 : unitRes;
            rrPtr_d     = ~grantId;
            if (!grantId && cnt0_q != '1) cnt0_d = cnt0_q + CntOne;
            if ( grantId && cnt1_q != '1) cnt1_d = cnt1_q + CntOne;
        end else if (resp_ready) begin
            // Payload fields keep their last values once the slot drains.
            respValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            respValid_q <= 1'b0;
            respId_q    <= 1'b0;
            respRes_q   <= '0;
            respErr_q   <= 1'b0;
            rrPtr_q     <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            respValid_q <= respValid_d;
            respId_q    <= respId_d;
            respRes_q   <= respRes_d;
            respErr_q   <= respErr_d;
            rrPtr_q     <= rrPtr_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign resp_valid = respValid_q;
    assign resp_id    = respId_q;
    assign resp_res   = respRes_q;
    assign resp_err   = respErr_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: doc/bitwise_arbiter.md
# bitwise_arbiter

Shares one `bitwise` logic unit (AND/OR/XOR, 2-bit `ctrl`) between two requesters, e.g. the integer pipeline's EX stage and a debug/scan port. Each cycle it arbitrates round-robin, drives the granted operands into the unit, and captures the result in a single registered response slot with valid/ready handshaking. Sits in the ALU cluster beside `bitwise`; the unit is instantiated internally.

## Interface
- `WIDTH`, 32, operand/result width; must match `bitwise`
- `CNT_W`, 8, width of per-requester grant counters
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req0_valid`, `req1_valid`  in  1 each  requester i has an operation pending
- `req0_ready`, `req1_ready`  out  1 each  requester i's operation is accepted this cycle
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH each  operands
- `req0_op`, `req1_op`  in  2 each  00 AND, 01 OR, 10 XOR, 11 illegal
- `resp_valid`  out  1  response slot holds a result
- `resp_ready`  in  1  consumer takes the response this cycle
- `resp_id`  out  1  requester that issued the response
- `resp_res`  out  WIDTH  result
- `resp_err`  out  1  op was 11; `resp_res` forced to 0
- `grant_cnt0`, `grant_cnt1`  out  CNT_W each  accepted-operation counts, saturating

## Operation
- Slot free: `free = !resp_valid || resp_ready`.
- Arbitration (combinational): only req0 valid -> grant 0; only req1 valid -> grant 1; both -> grant `rr_ptr`; neither -> no grant.
- `reqi_ready = free && grant==i`; readies may depend combinationally on both valids and on `resp_ready`. At most one ready high per cycle.
- Accept (valid && ready on requester i): `bitwise.a/b/ctrl` take requester i's operands/op; next cycle `resp_valid=1`, `resp_id=i`, `resp_res=bitwise.res`, `resp_err=0`; `rr_ptr <= ~i`; `grant_cnti` increments unless at all-ones.
- Op 11: accepted like any other; response has `resp_err=1`, `resp_res=0`; counts as a grant; `bitwise` output ignored.
- No accept, `resp_ready=1`: `resp_valid <= 0`; `resp_res`, `resp_id`, `resp_err` hold their last values.
- No accept, `resp_ready=0`: response slot and `rr_ptr` hold.
- `rr_ptr` changes only on accept, so a stalled loser keeps priority until it is served. No requester waits more than one accept behind the other.
- Requester inputs are not sampled unless accepted; a requester may drop valid without effect.

## Timing
- Reset (`rst_n=0` at an edge): `resp_valid=0`, `resp_id=0`, `resp_res=0`, `resp_err=0`, `rr_ptr=0` (req0 favoured), both counters 0. The reset overrides a same-cycle accept and drops any held response.
- Readies are low while `rst_n=0`.
- Latency: accepted at edge N -> `resp_valid` high after edge N; visible in cycle N+1.
- Throughput: one op/cycle when `resp_ready` is held high, alternating under contention.
- A full slot drained and refilled in the same cycle (`resp_ready=1` plus an accept): `resp_valid` stays 1 and the new result replaces the old with no bubble.
- Backpressure: `resp_valid && !resp_ready` -> both readies low; response outputs stable until taken.

## Test plan
- Reset, then req0 only: `a=FFFFFFFF`, `b=F0F0F0F0`, op 00 -> next cycle `resp_valid=1`, `resp_id=0`, `resp_res=F0F0F0F0`, `grant_cnt0=1`.
- req1 only, `resp_ready=1`: OR `FFFFFFFF|00000000` then XOR `FFFFFFFF^FFFFFFFF` on consecutive cycles -> responses `FFFFFFFF` then `00000000`, `resp_id=1`, no bubble.
- Both valid for 4 cycles, `resp_ready=1` -> `resp_id` sequence 0,1,0,1; both counters 2.
- Both valid, `resp_ready=0` for 3 cycles after the first accept -> readies low, `resp_res` stable. Release -> next grant goes to req1.
- req0 op 11 with `a=b=FFFFFFFF` -> `resp_err=1`, `resp_res=0`. Next legal op -> `resp_err=0`.
- Mid-stream reset with `resp_valid=1` -> after the edge every output is 0. Saturation check: 300 accepts on req0 -> `grant_cnt0=FF`.
